led_breath_engine: RTL and testbench

//  Multi-channel LED breathing engine: CHANNELS independent PWM outputs driven simultaneously
//  (no time-multiplexed output buffers), each following a triangle brightness ramp, per-channel

---
 rtl/led_breath_engine.sv | 161 ++++++++++++++++
 tb/tb_led_breath_engine.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_breath_engine.sv
// Multi-channel LED breathing engine: one shared PWM counter and ramp phase drive
// CHANNELS independent PWM outputs, each reconfigurable through a valid/ready shadow word.
module led_breath_engine #(
    parameter int CHANNELS   = 3,
    parameter int PWM_WIDTH  = 16,
    parameter int PWM_PERIOD = 46875,
    parameter int STEPS      = 256,
    parameter int PHASE_SKEW = 0,
    parameter int ACTIVE_LOW = 1,
    parameter int MODE_RESET = 3,
    parameter int PEAK_RESET = 46875
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [2*CHANNELS-1:0]           cfg_mode,
    input  logic [PWM_WIDTH*CHANNELS-1:0]   cfg_peak,
    output logic [CHANNELS-1:0]             pwm_o,
    output logic                            period_end,
    output logic                            cycle_end,
    output logic [$clog2(CHANNELS):0]       active_ch
);

    localparam int LOG_STEPS = $clog2(STEPS);
    localparam int P_W       = LOG_STEPS + 1;
    localparam int A_W       = $clog2(CHANNELS) + 1;
    localparam int PR_W      = PWM_WIDTH + P_W + 1;

    localparam logic [PWM_WIDTH-1:0] CNT_MAX  = PWM_WIDTH'(PWM_PERIOD - 1);
    localparam logic [PWM_WIDTH-1:0] DUTY_MAX = PWM_WIDTH'(PWM_PERIOD);
    localparam logic [P_W-1:0]       P_MAX    = P_W'(2 * STEPS - 1);
    localparam logic [P_W-1:0]       P_HALF   = P_W'(STEPS);
    localparam logic [P_W:0]         P_FULL   = (P_W + 1)'(2 * STEPS);
    localparam logic [A_W-1:0]       CH_MAX   = A_W'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0]  PWM_DARK = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        M_OFF     = 2'd0,
        M_ON      = 2'd1,
        M_BREATHE = 2'd2,
        M_SEQ     = 2'd3
    } mode_e;

    logic [PWM_WIDTH-1:0]                cnt_q, cnt_d;
    logic [P_W-1:0]                      p_q, p_d;
    logic [A_W-1:0]                      act_q, act_d;
    logic [CHANNELS-1:0][PWM_WIDTH-1:0]  duty_q, duty_d;
    logic [CHANNELS-1:0]                 pwm_q, pwm_d;
    logic [2*CHANNELS-1:0]               mode_q, mode_d, sh_mode_q, sh_mode_d;
    logic [PWM_WIDTH*CHANNELS-1:0]       peak_q, peak_d, sh_peak_q, sh_peak_d;
    logic                                pend_q, pend_d;
    logic                                rdy_q, rdy_d;

    logic                                accept, apply;
    logic [PWM_WIDTH-1:0]                pk, ramp, nxt;
    logic [P_W-1:0]                      q;
    logic [P_W:0]                        tri_v;
    logic [PR_W-1:0]                     prod;
    logic                                lit;

    always_comb begin
        period_end = enable && (cnt_q == CNT_MAX);
        cycle_end  = period_end && (p_q == P_MAX);
        // accept needs ready and apply needs pending; the two are never both set
        accept     = cfg_valid && rdy_q;
        apply      = period_end && pend_q;

        cnt_d     = cnt_q;
        p_d       = p_q;
        act_d     = act_q;
        duty_d    = duty_q;
        pwm_d     = PWM_DARK;
        mode_d    = mode_q;
        peak_d    = peak_q;
        sh_mode_d = sh_mode_q;
        sh_peak_d = sh_peak_q;
        pend_d    = pend_q;
        rdy_d     = rdy_q;
        pk        = '0;
        ramp      = '0;
        nxt       = '0;
        q         = '0;
        tri_v     = '0;
        prod      = '0;
        lit       = 1'b0;

        if (enable) cnt_d = period_end ? '0 : cnt_q + 1'b1;
        // 2*STEPS is a power of two, so p wraps by plain overflow
        if (period_end) p_d = p_q + 1'b1;
        if (cycle_end) act_d = (act_q == CH_MAX) ? '0 : act_q + 1'b1;

        if (accept) begin
            sh_mode_d = cfg_mode;
            sh_peak_d = cfg_peak;
            pend_d    = 1'b1;
            rdy_d     = 1'b0;
        end
        if (apply) begin
            mode_d = sh_mode_q;
            peak_d = sh_peak_q;
            pend_d = 1'b0;
            rdy_d  = 1'b1;
        end

        for (int i = 0; i < CHANNELS; i++) begin
            // next duty sees the freshly applied config and the post-increment phase
            pk    = (peak_d[PWM_WIDTH*i +: PWM_WIDTH] > DUTY_MAX) ? DUTY_MAX
                                                                  : peak_d[PWM_WIDTH*i +: PWM_WIDTH];
            q     = p_d + P_W'((i * PHASE_SKEW) % (2 * STEPS));
            tri_v = (q < P_HALF) ? {1'b0, q} : P_FULL - {1'b0, q};
            prod  = PR_W'(tri_v) * PR_W'(pk);
            ramp  = PWM_WIDTH'(prod >> LOG_STEPS);
            case (mode_e'(mode_d[2*i +: 2]))
                M_OFF:     nxt = '0;
                M_ON:      nxt = pk;
                M_BREATHE: nxt = ramp;
                M_SEQ:     nxt = (A_W'(i) == act_d) ? ramp : '0;
                default:   nxt = '0;
            endcase
            if (period_end) duty_d[i] = nxt;

            lit      = enable && (cnt_q < duty_q[i]);
            pwm_d[i] = (ACTIVE_LOW != 0) ? ~lit : lit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            p_q       <= '0;
            act_q     <= '0;
            duty_q    <= '0;
            pwm_q     <= PWM_DARK;
            mode_q    <= {CHANNELS{2'(MODE_RESET)}};
            peak_q    <= {CHANNELS{PWM_WIDTH'(PEAK_RESET)}};
            sh_mode_q <= '0;
            sh_peak_q <= '0;
            pend_q    <= 1'b0;
            rdy_q     <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            act_q     <= act_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            mode_q    <= mode_d;
            peak_q    <= peak_d;
            sh_mode_q <= sh_mode_d;
            sh_peak_q <= sh_peak_d;
            pend_q    <= pend_d;
            rdy_q     <= rdy_d;
        end
    end

    assign cfg_ready = rdy_q;
    assign pwm_o     = pwm_q;
    assign active_ch = act_q;

endmodule

// File: tb/tb_led_breath_engine.sv
// Self-checking bench for led_breath_engine: per-period lit-cycle counts are compared
// against expectations queued when each config word is driven.
module tb_led_breath_engine;

    localparam int CH = 3;
    localparam int PW = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [2*CH-1:0]   cfg_mode = '0;
    logic [PW*CH-1:0]  cfg_peak = '0;
    logic [CH-1:0]     pwm_o;
    logic              period_end;
    logic              cycle_end;
    logic [2:0]        active_ch;

    always #5 clk = ~clk;

    led_breath_engine #(
        .CHANNELS(3), .PWM_WIDTH(16), .PWM_PERIOD(8), .STEPS(4), .PHASE_SKEW(0),
        .ACTIVE_LOW(1), .MODE_RESET(3), .PEAK_RESET(46875)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_peak(cfg_peak),
        .pwm_o(pwm_o), .period_end(period_end), .cycle_end(cycle_end),
        .active_ch(active_ch)
    );

    typedef struct { int c[3]; } exp_t;
    typedef struct {
        logic [5:0]  mode;
        logic [47:0] peak;
        int          ex [3][8];
    } vec_t;

    exp_t sb[$];
    vec_t tbl[4];
    int   n_vec = 0;
    int   n_bad = 0;
    int   lit_cnt[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] ex);
        n_vec++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, ex);
        end
    endtask

    task automatic push3(input int a, input int b, input int c);
        exp_t e;
        e.c[0] = a; e.c[1] = b; e.c[2] = c;
        sb.push_back(e);
    endtask

    // leaves at the negedge just after release, counter at 0
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cfg_valid = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_pe(input int max, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!period_end && n < max);
        if (!period_end) chk("period_end timeout", 32'(period_end), 1);
    endtask

    task automatic wait_ce(input int max, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!cycle_end && n < max);
        if (!cycle_end) chk("cycle_end timeout", 32'(cycle_end), 1);
    endtask

    // pwm lags cnt by one cycle: eight consecutive samples cover one whole period
    task automatic measure();
        for (int c = 0; c < CH; c++) lit_cnt[c] = 0;
        repeat (8) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) if (!pwm_o[c]) lit_cnt[c]++;
        end
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        measure();
        if (sb.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            for (int c = 0; c < CH; c++)
                chk($sformatf("%s ch%0d lit", tag, c), lit_cnt[c], e.c[c]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;

        // breathe / on / off mixes; windows are periods p=1..7 then p=0
        tbl[0].mode = {2'd0, 2'd0, 2'd2};
        tbl[0].peak = {16'd0, 16'd0, 16'd8};
        tbl[0].ex[0] = '{2, 4, 6, 8, 6, 4, 2, 0};
        tbl[0].ex[1] = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[0].ex[2] = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].mode = {2'd2, 2'd1, 2'd1};
        tbl[1].peak = {16'd4, 16'd20, 16'd0};
        tbl[1].ex[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].ex[1] = '{8, 8, 8, 8, 8, 8, 8, 8};
        tbl[1].ex[2] = '{1, 2, 3, 4, 3, 2, 1, 0};
        tbl[2].mode = {2'd1, 2'd2, 2'd2};
        tbl[2].peak = {16'd5, 16'd6, 16'd3};
        tbl[2].ex[0] = '{0, 1, 2, 3, 2, 1, 0, 0};
        tbl[2].ex[1] = '{1, 3, 4, 6, 4, 3, 1, 0};
        tbl[2].ex[2] = '{5, 5, 5, 5, 5, 5, 5, 5};
        tbl[3].mode = {2'd3, 2'd3, 2'd3};
        tbl[3].peak = {16'd8, 16'd100, 16'd8};
        tbl[3].ex[0] = '{2, 4, 6, 8, 6, 4, 2, 0};
        tbl[3].ex[1] = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].ex[2] = '{0, 0, 0, 0, 0, 0, 0, 0};

        // reset state and first period_end position
        repeat (2) @(negedge clk);
        chk("reset pwm_o", 32'(pwm_o), 7);
        chk("reset cfg_ready", 32'(cfg_ready), 1);
        chk("reset active_ch", 32'(active_ch), 0);
        chk("reset period_end", 32'(period_end), 0);
        chk("reset cycle_end", 32'(cycle_end), 0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("period_end at cnt %0d", k), 32'(period_end), (k == 7) ? 1 : 0);
            if (k < 7) @(negedge clk);
        end

        // table-driven configurations
        for (int v = 0; v < 4; v++) begin
            do_reset();
            cfg_mode = tbl[v].mode;
            cfg_peak = tbl[v].peak;
            cfg_valid = 1'b1;
            for (int j = 0; j < 8; j++) push3(tbl[v].ex[0][j], tbl[v].ex[1][j], tbl[v].ex[2][j]);
            @(negedge clk);
            cfg_valid = 1'b0;
            chk($sformatf("vec%0d ready after accept", v), 32'(cfg_ready), 0);
            wait_pe(20, n);
            chk($sformatf("vec%0d first period_end", v), n, 6);
            chk($sformatf("vec%0d ready at apply", v), 32'(cfg_ready), 0);
            @(negedge clk);
            chk($sformatf("vec%0d ready after apply", v), 32'(cfg_ready), 1);
            for (int j = 0; j < 8; j++) sb_check($sformatf("vec%0d p%0d", v, (j + 1) % 8));
        end

        // accept mid-period, valid ignored while busy, accept on period_end
        do_reset();
        repeat (3) @(negedge clk);
        cfg_mode = {2'd0, 2'd0, 2'd1};
        cfg_peak = {16'd0, 16'd0, 16'd5};
        cfg_valid = 1'b1;
        push3(5, 0, 0);
        @(negedge clk);
        chk("cnt3 accept ready", 32'(cfg_ready), 0);
        cfg_mode = 6'd0;
        repeat (3) @(negedge clk);
        chk("cnt3 period_end", 32'(period_end), 1);
        chk("cnt3 ready held low", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("cnt3 ready restored", 32'(cfg_ready), 1);
        sb_check("cnt3 cfg");
        wait_pe(20, n);
        cfg_mode = {2'd0, 2'd0, 2'd1};
        cfg_peak = {16'd0, 16'd0, 16'd3};
        cfg_valid = 1'b1;
        push3(5, 0, 0);
        push3(3, 0, 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("pe accept ready", 32'(cfg_ready), 0);
        sb_check("pe accept old");
        sb_check("pe accept new");

        // sequence mode walks active_ch, defaults clamp peak to the period
        do_reset();
        wait_ce(200, n);
        chk("first cycle_end cycle", n, 63);
        chk("active_ch before wrap", 32'(active_ch), 0);
        @(negedge clk);
        chk("active_ch step 1", 32'(active_ch), 1);
        push3(0, 0, 0); push3(0, 2, 0); push3(0, 4, 0); push3(0, 6, 0);
        for (int j = 0; j < 4; j++) sb_check($sformatf("seq ch1 p%0d", j));
        wait_ce(200, n);
        @(negedge clk);
        chk("active_ch step 2", 32'(active_ch), 2);
        wait_ce(200, n);
        chk("cycle_end spacing", n, 63);
        @(negedge clk);
        chk("active_ch wrap", 32'(active_ch), 0);
        wait_ce(200, n);
        for (int j = 0; j < 3; j++) wait_pe(20, n);

        // reset mid-breath with config pending
        cfg_mode = {2'd1, 2'd1, 2'd1};
        cfg_peak = {16'd8, 16'd8, 16'd8};
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("ch1 lit before reset", 32'(pwm_o[1]), 0);
        chk("cfg pending before reset", 32'(cfg_ready), 0);
        #2 reset = 1'b1;
        #1;
        chk("async reset pwm_o", 32'(pwm_o), 7);
        chk("async reset ready", 32'(cfg_ready), 1);
        chk("async reset active_ch", 32'(active_ch), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push3(2, 0, 0);
        wait_pe(20, n);
        @(negedge clk);
        sb_check("post reset defaults");

        // enable low freezes and darkens; pending config waits
        do_reset();
        cfg_mode = {2'd0, 2'd0, 2'd1};
        cfg_peak = {16'd0, 16'd0, 16'd8};
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_pe(20, n);
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("ch0 lit before freeze", 32'(pwm_o[0]), 0);
        enable = 1'b0;
        cfg_mode = 6'd0;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("freeze pwm dark", 32'(pwm_o), 7);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (pwm_o !== 3'b111 || period_end !== 1'b0 || cycle_end !== 1'b0) bad++;
        end
        chk("freeze violations", bad, 0);
        chk("freeze cfg pending", 32'(cfg_ready), 0);
        enable = 1'b1;
        @(negedge clk);
        chk("resume ch0 lit", 32'(pwm_o[0]), 0);
        wait_pe(20, n);
        chk("resume cycles to period_end", n, 3);
        @(negedge clk);
        chk("resume ready after apply", 32'(cfg_ready), 1);
        push3(0, 0, 0);
        sb_check("resume cfg applied");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
